// File: rtl/dm_pkg.sv
// Shared types for the data memory controller: access-size encodings,
// controller states and the alignment rule.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  // The reserved size always faults, so it never reaches the memory.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ad_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = ad_lo[0];
      SZ_WORD: bad = (ad_lo != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_if.sv
// Request/response bus between the datapath and the data memory controller.
interface dm_if #(
  parameter int AW = 8
);
  // Handshake: a request is taken on a rising edge where Req && Ready. Request
  // fields are sampled only on that edge. Valid is a one-cycle strobe; DM and
  // Misalign are meaningful only while Valid = 1. There is no backpressure on
  // the response side and no request queue.
  logic          Req;
  logic          We;
  logic [1:0]    Size;
  logic          Unsigned;
  logic [AW-1:0] Ad;
  logic [31:0]   WrData;
  logic          Ready;
  logic          Valid;
  logic [31:0]   DM;
  logic          Misalign;

  modport master (
    output Req, We, Size, Unsigned, Ad, WrData,
    input  Ready, Valid, DM, Misalign
  );

  modport slave (
    input  Req, We, Size, Unsigned, Ad, WrData,
    output Ready, Valid, DM, Misalign
  );
endinterface

// File: rtl/dm_byte_lane.sv
// Little-endian lane steering: store lane enables and replicated write data,
// plus byte/half extraction and sign or zero extension for loads.
module dm_byte_lane
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  ad_lo,
  input  logic        zero_ext,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  lane_en,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Write data is replicated across lanes so only the enables need steering.
  always_comb begin
    lane_en = 4'b0000;
    wr_word = wr_data;
    case (size)
      SZ_BYTE: begin
        lane_en = 4'b0001 << ad_lo;
        wr_word = {4{wr_data[7:0]}};
      end
      SZ_HALF: begin
        lane_en = ad_lo[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wr_data[15:0]}};
      end
      SZ_WORD: begin
        lane_en = 4'b1111;
        wr_word = wr_data;
      end
      default: begin
        lane_en = 4'b0000;
        wr_word = wr_data;
      end
    endcase
  end

  always_comb begin
    rd_byte = rd_word[7:0];
    case (ad_lo)
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
    rd_half = ad_lo[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    rd_data = rd_word;
    case (size)
      SZ_BYTE: rd_data = zero_ext ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SZ_HALF: rd_data = zero_ext ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: rd_data = rd_word;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed 32-bit data memory with configurable access latency,
// misalignment faulting and an optional post-reset clearing sweep.
module data_memory_ctrl
  import dm_pkg::*;
#(
  parameter int AW         = 8,
  parameter int LATENCY    = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic   Clk,
  input  logic   Reset_n,
  dm_if.slave    bus,
  output state_t dbg_state
);

  localparam int             WA        = AW - 2;
  localparam int             DEPTH     = 1 << WA;
  localparam logic [WA-1:0]  LAST_WORD = WA'(DEPTH - 1);
  localparam logic [3:0]     WLOAD     = 4'(LATENCY - 1);

  state_t        state;
  logic [WA-1:0] clr_cnt;
  logic [3:0]    wcnt;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW-1:0] ad_q;
  logic [31:0]   wd_q;
  logic          ready_q;
  logic          valid_q;
  logic          mis_q;
  logic [31:0]   dm_q;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_word;
  logic [31:0]   rd_data;
  logic [31:0]   wr_word;
  logic [3:0]    lane_en;
  logic          access_edge;
  logic          clr_we;
  logic          acc_we;

  assign rd_word     = mem[ad_q[AW-1:2]];
  assign access_edge = (state == ST_BUSY) && (wcnt == 4'd0);
  assign clr_we      = Reset_n && (state == ST_INIT);
  assign acc_we      = Reset_n && access_edge && we_q;

  dm_byte_lane u_lane (
    .size     (size_q),
    .ad_lo    (ad_q[1:0]),
    .zero_ext (uns_q),
    .wr_data  (wd_q),
    .rd_word  (rd_word),
    .lane_en  (lane_en),
    .wr_word  (wr_word),
    .rd_data  (rd_data)
  );

  // Storage is not reset; the INIT sweep provides known contents instead.
  always_ff @(posedge Clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[ad_q[AW-1:2]][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;
      clr_cnt <= '0;
      wcnt    <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      ad_q    <= '0;
      wd_q    <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      dm_q    <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (clr_cnt == LAST_WORD) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (bus.Req && ready_q) begin
            we_q    <= bus.We;
            size_q  <= bus.Size;
            uns_q   <= bus.Unsigned;
            ad_q    <= bus.Ad;
            wd_q    <= bus.WrData;
            wcnt    <= WLOAD;
            ready_q <= 1'b0;
            // A faulting request skips the latency wait entirely.
            if (is_misaligned(bus.Size, bus.Ad[1:0])) begin
              state   <= ST_RESP;
              valid_q <= 1'b1;
              mis_q   <= 1'b1;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (wcnt == 4'd0) begin
            state   <= ST_RESP;
            valid_q <= 1'b1;
            mis_q   <= 1'b0;
            if (!we_q) dm_q <= rd_data;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        ST_RESP: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
          mis_q   <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Ready    = ready_q;
  assign bus.Valid    = valid_q;
  assign bus.DM       = dm_q;
  assign bus.Misalign = mis_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one instance at LATENCY=1, one at
// LATENCY=4, both with AW=6 (16 words).
module tb_data_memory_ctrl;
  import dm_pkg::*;

  logic   clk;
  logic   rst1_n;
  logic   rst4_n;
  state_t dbg1;
  state_t dbg4;
  int     n_tests;
  int     n_fail;

  dm_if #(.AW(6)) b1 ();
  dm_if #(.AW(6)) b4 ();

  data_memory_ctrl #(.AW(6), .LATENCY(1), .INIT_CLEAR(1)) dut1 (
    .Clk(clk), .Reset_n(rst1_n), .bus(b1), .dbg_state(dbg1)
  );
  data_memory_ctrl #(.AW(6), .LATENCY(4), .INIT_CLEAR(1)) dut4 (
    .Clk(clk), .Reset_n(rst4_n), .bus(b4), .dbg_state(dbg4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit sel4, input logic req, input logic we, input logic [1:0] size,
                       input logic uns, input logic [5:0] ad, input logic [31:0] wd);
    if (sel4) begin
      b4.Req = req; b4.We = we; b4.Size = size; b4.Unsigned = uns; b4.Ad = ad; b4.WrData = wd;
    end else begin
      b1.Req = req; b1.We = we; b1.Size = size; b1.Unsigned = uns; b1.Ad = ad; b1.WrData = wd;
    end
  endtask

  // Issue one request and wait for its Valid; cyc counts negedges from accept to Valid.
  task automatic access(input bit sel4, input logic we, input logic [1:0] size, input logic uns,
                        input logic [5:0] ad, input logic [31:0] wd,
                        output int cyc, output logic [31:0] dm, output logic mis);
    int   guard;
    logic v;
    guard = 0;
    while (!(sel4 ? b4.Ready : b1.Ready) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL access_ready_timeout: Ready=0 expected 1 within 50 cycles");
    end
    drive(sel4, 1'b1, we, size, uns, ad, wd);
    cyc = 0;
    v   = 1'b0;
    while (!v && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (sel4) b4.Req = 1'b0; else b1.Req = 1'b0;
      v = sel4 ? b4.Valid : b1.Valid;
    end
    if (!v) begin
      n_tests++; n_fail++;
      $display("FAIL access_valid_timeout: Valid=0 expected 1 within 40 cycles");
    end
    dm  = sel4 ? b4.DM : b1.DM;
    mis = sel4 ? b4.Misalign : b1.Misalign;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    int          cyc;
    logic [31:0] dm;
    logic        mis;
    logic        exp_rdy;
    rst1_n = 1'b0;
    rst4_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 6'h00, 32'h0);
    drive(1'b1, 1'b0, 1'b0, SZ_WORD, 1'b0, 6'h00, 32'h0);
    repeat (3) @(negedge clk);
    n_tests++; if (b1.Ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", b1.Ready); end
    n_tests++; if (b1.Valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", b1.Valid); end
    n_tests++; if (b1.DM !== 32'h0) begin n_fail++; $display("FAIL rst_dm: got %h expected 00000000", b1.DM); end
    n_tests++; if (b1.Misalign !== 1'b0) begin n_fail++; $display("FAIL rst_mis: got %b expected 0", b1.Misalign); end
    n_tests++; if (dbg1 !== ST_INIT) begin n_fail++; $display("FAIL rst_state: got %0d expected %0d", dbg1, ST_INIT); end
    // A store attempted during INIT must be ignored.
    drive(1'b0, 1'b1, 1'b1, SZ_WORD, 1'b0, 6'h24, 32'hFFFFFFFF);
    rst1_n = 1'b1;
    rst4_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp_rdy = (i == 16);
      n_tests++; if (b1.Ready !== exp_rdy) begin n_fail++; $display("FAIL init_ready1 cyc %0d: got %b expected %b", i, b1.Ready, exp_rdy); end
      n_tests++; if (b4.Ready !== exp_rdy) begin n_fail++; $display("FAIL init_ready4 cyc %0d: got %b expected %b", i, b4.Ready, exp_rdy); end
      if (i == 15) b1.Req = 1'b0;
    end
    access(1'b0, 1'b0, SZ_WORD, 1'b0, 6'h24, 32'h0, cyc, dm, mis);
    n_tests++; if (dm !== 32'h0) begin n_fail++; $display("FAIL init_load: got %h expected 00000000", dm); end
    n_tests++; if (mis !== 1'b0) begin n_fail++; $display("FAIL init_load_mis: got %b expected 0", mis); end
  endtask

  task automatic test_word_byte();
    int          cyc;
    logic [31:0] dm;
    logic        mis;
    access(1'b0, 1'b1, SZ_WORD, 1'b0, 6'h10, 32'h8899AABB, cyc, dm, mis);
    n_tests++; if (cyc !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d expected 2", cyc); end
    n_tests++; if (mis !== 1'b0) begin n_fail++; $display("FAIL sw_mis: got %b expected 0", mis); end
    n_tests++; if (dm !== 32'h0) begin n_fail++; $display("FAIL sw_dm_hold: got %h expected 00000000", dm); end
    access(1'b0, 1'b0, SZ_BYTE, 1'b0, 6'h13, 32'h0, cyc, dm, mis);
    n_tests++; if (dm !== 32'hFFFFFF88) begin n_fail++; $display("FAIL lb_13: got %h expected FFFFFF88", dm); end
    access(1'b0, 1'b0, SZ_BYTE, 1'b1, 6'h13, 32'h0, cyc, dm, mis);
    n_tests++; if (dm !== 32'h00000088) begin n_fail++; $display("FAIL lbu_13: got %h expected 00000088", dm); end
    access(1'b0, 1'b0, SZ_BYTE, 1'b0, 6'h10, 32'h0, cyc, dm, mis);
    n_tests++; if (dm !== 32'hFFFFFFBB) begin n_fail++; $display("FAIL lb_10: got %h expected FFFFFFBB", dm); end
  endtask

  task automatic test_half();
    int          cyc;
    logic [31:0] dm;
    logic        mis;
    access(1'b0, 1'b1, SZ_HALF, 1'b0, 6'h12, 32'hDEAD1234, cyc, dm, mis);
    n_tests++; if (dm !== 32'hFFFFFFBB) begin n_fail++; $display("FAIL sh_dm_hold: got %h expected FFFFFFBB", dm); end
    n_tests++; if (mis !== 1'b0) begin n_fail++; $display("FAIL sh_mis: got %b expected 0", mis); end
    access(1'b0, 1'b0, SZ_WORD, 1'b0, 6'h10, 32'h0, cyc, dm, mis);
    n_tests++; if (dm !== 32'h1234AABB) begin n_fail++; $display("FAIL lw_after_sh: got %h expected 1234AABB", dm); end
    access(1'b0, 1'b0, SZ_HALF, 1'b0, 6'h12, 32'h0, cyc, dm, mis);
    n_tests++; if (dm !== 32'h00001234) begin n_fail++; $display("FAIL lh_12: got %h expected 00001234", dm); end
    access(1'b0, 1'b0, SZ_HALF, 1'b0, 6'h10, 32'h0, cyc, dm, mis);
    n_tests++; if (dm !== 32'hFFFFAABB) begin n_fail++; $display("FAIL lh_10: got %h expected FFFFAABB", dm); end
    access(1'b0, 1'b1, SZ_BYTE, 1'b0, 6'h11, 32'hFFFFFF5A, cyc, dm, mis);
    access(1'b0, 1'b0, SZ_WORD, 1'b0, 6'h10, 32'h0, cyc, dm, mis);
    n_tests++; if (dm !== 32'h12345ABB) begin n_fail++; $display("FAIL lw_after_sb: got %h expected 12345ABB", dm); end
    access(1'b0, 1'b0, SZ_HALF, 1'b1, 6'h10, 32'h0, cyc, dm, mis);
    n_tests++; if (dm !== 32'h00005ABB) begin n_fail++; $display("FAIL lhu_10: got %h expected 00005ABB", dm); end
  endtask

  task automatic test_misalign();
    int          cyc;
    logic [31:0] dm;
    logic        mis;
    access(1'b0, 1'b0, SZ_WORD, 1'b0, 6'h11, 32'h0, cyc, dm, mis);
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL mis_lw_latency: got %0d expected 1", cyc); end
    n_tests++; if (mis !== 1'b1) begin n_fail++; $display("FAIL mis_lw_flag: got %b expected 1", mis); end
    n_tests++; if (dm !== 32'h00005ABB) begin n_fail++; $display("FAIL mis_lw_dm: got %h expected 00005ABB", dm); end
    access(1'b0, 1'b1, SZ_HALF, 1'b0, 6'h13, 32'h0000FFFF, cyc, dm, mis);
    n_tests++; if (mis !== 1'b1 || cyc !== 1) begin n_fail++; $display("FAIL mis_sh: got mis=%b cyc=%0d expected mis=1 cyc=1", mis, cyc); end
    access(1'b0, 1'b1, SZ_RSVD, 1'b0, 6'h10, 32'h00000000, cyc, dm, mis);
    n_tests++; if (mis !== 1'b1 || cyc !== 1) begin n_fail++; $display("FAIL mis_rsvd: got mis=%b cyc=%0d expected mis=1 cyc=1", mis, cyc); end
    access(1'b0, 1'b0, SZ_HALF, 1'b1, 6'h11, 32'h0, cyc, dm, mis);
    n_tests++; if (mis !== 1'b1 || dm !== 32'h00005ABB) begin n_fail++; $display("FAIL mis_lh: got mis=%b dm=%h expected mis=1 dm=00005ABB", mis, dm); end
    access(1'b0, 1'b0, SZ_WORD, 1'b0, 6'h10, 32'h0, cyc, dm, mis);
    n_tests++; if (dm !== 32'h12345ABB || mis !== 1'b0) begin n_fail++; $display("FAIL mis_mem_intact: got dm=%h mis=%b expected dm=12345ABB mis=0", dm, mis); end
  endtask

  task automatic test_back_to_back();
    int          cyc;
    logic [31:0] dm;
    logic        mis;
    logic [31:0] exp_dm;
    logic        exp_v;
    logic        exp_r;
    int          nxt;
    access(1'b1, 1'b1, SZ_WORD, 1'b0, 6'h04, 32'h11111111, cyc, dm, mis);
    n_tests++; if (cyc !== 5) begin n_fail++; $display("FAIL lat4_latency: got %0d expected 5", cyc); end
    access(1'b1, 1'b1, SZ_WORD, 1'b0, 6'h08, 32'h22222222, cyc, dm, mis);
    @(negedge clk);
    n_tests++; if (b4.Ready !== 1'b1) begin n_fail++; $display("FAIL b2b_start_ready: got %b expected 1", b4.Ready); end
    // Req stays high; only the address presented at an accept edge may be used.
    drive(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 6'h04, 32'h0);
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      exp_v = ((j % 6) == 4);
      exp_r = ((j % 6) == 5);
      n_tests++; if (b4.Valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid cyc %0d: got %b expected %b", j, b4.Valid, exp_v); end
      n_tests++; if (b4.Ready !== exp_r) begin n_fail++; $display("FAIL b2b_ready cyc %0d: got %b expected %b", j, b4.Ready, exp_r); end
      if (exp_v) begin
        exp_dm = ((j / 6) % 2 == 1) ? 32'h22222222 : 32'h11111111;
        n_tests++; if (b4.DM !== exp_dm) begin n_fail++; $display("FAIL b2b_dm cyc %0d: got %h expected %h", j, b4.DM, exp_dm); end
      end
      nxt = j + 1;
      if ((nxt % 6) == 0) b4.Ad = ((nxt / 6) % 2 == 1) ? 6'h08 : 6'h04;
      else                b4.Ad = 6'h3C;
      if (j == 17) b4.Req = 1'b0;
    end
  endtask

  task automatic test_reset_abort();
    int          cyc;
    logic [31:0] dm;
    logic        mis;
    logic        exp_rdy;
    drive(1'b1, 1'b1, 1'b1, SZ_WORD, 1'b0, 6'h20, 32'hCAFEF00D);
    @(negedge clk);
    b4.Req = 1'b0;
    n_tests++; if (b4.Ready !== 1'b0) begin n_fail++; $display("FAIL abort_accepted: got Ready=%b expected 0", b4.Ready); end
    @(negedge clk);
    rst4_n = 1'b0;
    #1;
    n_tests++; if (b4.Valid !== 1'b0 || b4.Misalign !== 1'b0) begin n_fail++; $display("FAIL abort_flags: got V=%b M=%b expected 0 0", b4.Valid, b4.Misalign); end
    n_tests++; if (b4.DM !== 32'h0) begin n_fail++; $display("FAIL abort_dm: got %h expected 00000000", b4.DM); end
    n_tests++; if (dbg4 !== ST_INIT) begin n_fail++; $display("FAIL abort_state: got %0d expected %0d", dbg4, ST_INIT); end
    @(negedge clk);
    rst4_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp_rdy = (i == 16);
      n_tests++; if (b4.Ready !== exp_rdy) begin n_fail++; $display("FAIL reinit_ready cyc %0d: got %b expected %b", i, b4.Ready, exp_rdy); end
    end
    access(1'b1, 1'b0, SZ_WORD, 1'b0, 6'h20, 32'h0, cyc, dm, mis);
    n_tests++; if (dm !== 32'h0) begin n_fail++; $display("FAIL abort_load20: got %h expected 00000000", dm); end
    access(1'b1, 1'b0, SZ_WORD, 1'b0, 6'h04, 32'h0, cyc, dm, mis);
    n_tests++; if (dm !== 32'h0) begin n_fail++; $display("FAIL reinit_load04: got %h expected 00000000", dm); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_word_byte();
    test_half();
    test_misalign();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
